// File: rtl/coleta_senha_pkg.sv
// rtl/coleta_senha_pkg.sv - shared types and constants for keypad password collection
package coleta_senha_pkg;

    localparam int         MAX_DIGITS  = 20;
    localparam logic [3:0] DIGIT_EMPTY = 4'hF;
    localparam logic [3:0] KEY_BKSP    = 4'hA;
    localparam logic [3:0] KEY_ENTER   = 4'hB;

    typedef struct packed {
        logic [MAX_DIGITS-1:0][3:0] digits;
    } senhaPac_t;

    typedef enum logic [1:0] {
        VAZIO,
        COLETANDO,
        ENVIANDO,
        AGUARDA
    } estado_t;

    localparam senhaPac_t SENHA_VAZIA = '{digits: {MAX_DIGITS{DIGIT_EMPTY}}};

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/coleta_senha_temporizador.sv
// rtl/coleta_senha_temporizador.sv - keypad inactivity timer, flags terminal count
module temporizador_inatividade #(
    parameter int TIMEOUT_CYC = 250_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int             W        = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [W-1:0]   TERMINAL = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] count;

    // Saturates at terminal count; the owner decides what expiry means.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear || !enable) begin
            count <= '0;
        end else if (count != TERMINAL) begin
            count <= count + W'(1);
        end
    end

    assign expired = enable && (count == TERMINAL);

endmodule

// File: rtl/coleta_senha.sv
// rtl/coleta_senha.sv - collects keypad digits into a password buffer for the checker
module coleta_senha
    import coleta_senha_pkg::*;
#(
    parameter int TIMEOUT_CYC = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       done_in,
    output senhaPac_t  senha_out,
    output logic       valid_out,
    output logic [4:0] n_digits,
    output logic       busy,
    output logic       timeout
);

    localparam logic [4:0] MAX_N = 5'(MAX_DIGITS);

    estado_t state;
    logic    key_accepted;
    logic    expired;

    // ENTER/BKSP only matter once at least one digit is held.
    always_comb begin
        key_accepted = 1'b0;
        if (key_valid) begin
            if (state == VAZIO)
                key_accepted = is_digit(key_code);
            else if (state == COLETANDO)
                key_accepted = (key_code <= KEY_ENTER);
        end
    end

    temporizador_inatividade #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_temporizador (
        .clk     (clk),
        .rst     (rst),
        .clear   (key_accepted),
        .enable  (state == COLETANDO),
        .expired (expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= VAZIO;
            senha_out <= SENHA_VAZIA;
            n_digits  <= '0;
            valid_out <= 1'b0;
            busy      <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                VAZIO: begin
                    if (key_accepted) begin
                        senha_out.digits[0] <= key_code;
                        n_digits            <= 5'd1;
                        state               <= COLETANDO;
                    end
                end
                COLETANDO: begin
                    if (key_accepted) begin
                        if (is_digit(key_code)) begin
                            if (n_digits == MAX_N) begin
                                // Full window slides; the oldest digit drops out.
                                senha_out.digits <= {key_code, senha_out.digits[MAX_DIGITS-1:1]};
                            end else begin
                                senha_out.digits[n_digits] <= key_code;
                                n_digits                   <= n_digits + 5'd1;
                            end
                        end else if (key_code == KEY_BKSP) begin
                            senha_out.digits[n_digits - 5'd1] <= DIGIT_EMPTY;
                            n_digits                          <= n_digits - 5'd1;
                            if (n_digits == 5'd1)
                                state <= VAZIO;
                        end else begin
                            valid_out <= 1'b1;
                            busy      <= 1'b1;
                            state     <= ENVIANDO;
                        end
                    end else if (expired) begin
                        senha_out <= SENHA_VAZIA;
                        n_digits  <= '0;
                        timeout   <= 1'b1;
                        state     <= VAZIO;
                    end
                end
                ENVIANDO: begin
                    state <= AGUARDA;
                end
                AGUARDA: begin
                    if (done_in) begin
                        senha_out <= SENHA_VAZIA;
                        n_digits  <= '0;
                        busy      <= 1'b0;
                        state     <= VAZIO;
                    end
                end
                default: begin
                    state <= VAZIO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coleta_senha.sv
// tb/tb_coleta_senha.sv - randomized and directed bench for coleta_senha against a queue model
module tb_coleta_senha;
    import coleta_senha_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic       done_in = 1'b0;
    senhaPac_t  senha_out;
    logic       valid_out;
    logic [4:0] n_digits;
    logic       busy;
    logic       timeout;

    always #5 clk = ~clk;

    coleta_senha #(.TIMEOUT_CYC(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_code  (key_code),
        .done_in   (done_in),
        .senha_out (senha_out),
        .valid_out (valid_out),
        .n_digits  (n_digits),
        .busy      (busy),
        .timeout   (timeout)
    );

    int errors = 0;
    int checks = 0;

    // Reference: the password is a queue of digits, oldest first.
    int q[$];
    bit m_busy, m_valid, m_timeout;
    int idle;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] exp_senha();
        logic [79:0] v;
        v = '1;
        for (int i = 0; i < q.size(); i++) v[i*4 +: 4] = 4'(q[i]);
        return v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_valid = 0; m_timeout = 0; idle = 0;
    endtask

    task automatic model_step(input bit kv, input logic [3:0] kc, input bit dn);
        bit was_valid;
        was_valid = m_valid;
        m_valid   = 0;
        m_timeout = 0;
        if (m_busy) begin
            if (!was_valid && dn) begin
                q.delete();
                m_busy = 0;
            end
        end else if (kv && (kc <= 4'd9 || (kc <= 4'hB && q.size() > 0))) begin
            idle = 0;
            if (kc <= 4'd9) begin
                q.push_back(int'(kc));
                if (q.size() > 20) void'(q.pop_front());
            end else if (kc == 4'hA) begin
                void'(q.pop_back());
            end else begin
                m_busy  = 1;
                m_valid = 1;
            end
        end else if (q.size() > 0) begin
            if (idle == TO - 1) begin
                q.delete();
                m_timeout = 1;
                idle = 0;
            end else begin
                idle++;
            end
        end
    endtask

    task automatic compare_all(input string where);
        check({where, ".senha"},   senha_out,         exp_senha());
        check({where, ".n"},       80'(n_digits),     80'(q.size()));
        check({where, ".busy"},    80'(busy),         80'(m_busy));
        check({where, ".valid"},   80'(valid_out),    80'(m_valid));
        check({where, ".timeout"}, 80'(timeout),      80'(m_timeout));
    endtask

    task automatic cycle(input string where, input bit kv, input logic [3:0] kc, input bit dn);
        key_valid = kv;
        key_code  = kc;
        done_in   = dn;
        @(posedge clk);
        model_step(kv, kc, dn);
        @(negedge clk);
        key_valid = 1'b0;
        done_in   = 1'b0;
        compare_all(where);
    endtask

    task automatic press(input string where, input logic [3:0] kc);
        cycle(where, 1'b1, kc, 1'b0);
    endtask

    task automatic idle_cycles(input string where, input int n);
        for (int i = 0; i < n; i++) cycle(where, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic async_reset(input string where);
        #2 rst = 1'b0;
        #1 model_reset();
        compare_all(where);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [79:0] exp2;
        int pulses;

        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare_all("reset");
        rst = 1'b1;

        // 1: short password, submit, release
        press("t1", 4'd1); press("t1", 4'd2); press("t1", 4'd3); press("t1", 4'd4);
        check("t1.n4", 80'(n_digits), 80'd4);
        press("t1.enter", KEY_ENTER);
        check("t1.valid_pulse", 80'(valid_out), 80'd1);
        idle_cycles("t1.hold", 5);
        check("t1.busy_hold", 80'(busy), 80'd1);
        cycle("t1.done", 1'b0, 4'h0, 1'b1);
        check("t1.cleared", senha_out, '1);

        // 2: overflow slides the window
        for (int r = 0; r < 2; r++)
            for (int d = 0; d < 10; d++) press("t2", 4'(d));
        press("t2", 4'd7); press("t2", 4'd8);
        press("t2.enter", KEY_ENTER);
        exp2 = '1;
        for (int i = 0; i < 8; i++)  exp2[i*4 +: 4] = 4'(i + 2);
        for (int i = 0; i < 10; i++) exp2[(i+8)*4 +: 4] = 4'(i);
        exp2[18*4 +: 4] = 4'd7;
        exp2[19*4 +: 4] = 4'd8;
        check("t2.window", senha_out, exp2);
        check("t2.n20", 80'(n_digits), 80'd20);
        cycle("t2.done", 1'b0, 4'h0, 1'b0);
        cycle("t2.done", 1'b0, 4'h0, 1'b1);

        // 3: backspace down to empty, extra BKSP ignored
        press("t3", 4'd5); press("t3", 4'd6);
        press("t3", KEY_BKSP); press("t3", KEY_BKSP);
        check("t3.n0", 80'(n_digits), 80'd0);
        press("t3", KEY_BKSP);
        press("t3.enter_empty", KEY_ENTER);
        check("t3.no_valid", 80'(busy), 80'd0);

        // 4: inactivity clear, then key on the terminal-count cycle
        press("t4", 4'd3);
        pulses = 0;
        for (int i = 0; i < TO; i++) begin
            cycle("t4.idle", 1'b0, 4'h0, 1'b0);
            if (timeout) pulses++;
        end
        check("t4.one_timeout", 80'(pulses), 80'd1);
        press("t4v", 4'd3);
        idle_cycles("t4v.idle", TO - 1);
        press("t4v.terminal", 4'd4);
        check("t4v.n2", 80'(n_digits), 80'd2);
        check("t4v.no_timeout", 80'(timeout), 80'd0);
        idle_cycles("t4v.after", 3);

        // 5: keys dropped while waiting on the checker
        press("t5.enter", KEY_ENTER);
        press("t5.drop", 4'd9); press("t5.drop", 4'd9);
        check("t5.held_n", 80'(n_digits), 80'd2);
        cycle("t5.done", 1'b0, 4'h0, 1'b1);

        // 6: async reset mid-AGUARDA and mid-entry
        press("t6", 4'd1); press("t6.enter", KEY_ENTER); idle_cycles("t6", 2);
        async_reset("t6.rst_aguarda");
        press("t6", 4'd4);
        check("t6.n1", 80'(n_digits), 80'd1);
        press("t6", 4'd2);
        async_reset("t6.rst_entry");

        // Random traffic with alternating key density so timeouts also occur
        for (int i = 0; i < 4000; i++) begin
            bit kv, dn;
            logic [3:0] kc;
            int sel;
            if ((i / 200) % 2 == 0) kv = ($urandom_range(0, 1) == 0);
            else                    kv = ($urandom_range(0, 11) == 0);
            sel = $urandom_range(0, 99);
            if (sel < 60)      kc = 4'($urandom_range(0, 9));
            else if (sel < 78) kc = KEY_BKSP;
            else if (sel < 88) kc = KEY_ENTER;
            else               kc = 4'($urandom_range(12, 15));
            dn = ($urandom_range(0, 5) == 0);
            cycle("rand", kv, kc, dn);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
